// File: rtl/aes_encipher_ctrl.sv
// aes_encipher_ctrl
// Round sequencer placed in front of the combinational AES encipher round
// logic. Captures a plaintext block, walks it through one initial round,
// Nr-1 main rounds and one final round, and hands the ciphertext back over
// a ready/valid handshake. All outputs come straight from registers.

module aes_encipher_ctrl #(
  parameter int NR128 = 10,
  parameter int NR256 = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  output logic [1:0]   round_type,
  output logic [127:0] round_state,
  input  logic [127:0] round_result,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         valid
);

  // Round type encoding seen by the round logic; 2'd3 is never produced.
  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MAIN  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;

  // Round counts narrowed to the 4-bit round counter width.
  localparam logic [3:0] NR128_W = NR128[3:0];
  localparam logic [3:0] NR256_W = NR256[3:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_MAIN  = 2'd2,
    ST_FINAL = 2'd3
  } fsm_e;

  fsm_e         fsm_r;
  logic [127:0] state_r;
  logic [127:0] new_block_r;
  logic [3:0]   nr_r;
  logic [3:0]   round_r;
  logic [1:0]   round_type_r;
  logic         ready_r;
  logic         valid_r;
  logic [3:0]   last_main_s;

  // Round index of the last main round; reaching it hands over to FINAL.
  always_comb begin
    last_main_s = nr_r - 4'd1;
  end

  // Sequencer: owns the state register, round index/type and the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r        <= ST_IDLE;
      state_r      <= 128'd0;
      new_block_r  <= 128'd0;
      nr_r         <= NR128_W;
      round_r      <= 4'd0;
      round_type_r <= RT_INIT;
      ready_r      <= 1'b1;
      valid_r      <= 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (next) begin
            state_r      <= block;
            nr_r         <= keylen ? NR256_W : NR128_W;
            round_r      <= 4'd0;
            round_type_r <= RT_INIT;
            ready_r      <= 1'b0;
            valid_r      <= 1'b0;
            fsm_r        <= ST_INIT;
          end
        end

        ST_INIT: begin
          state_r      <= round_result;
          round_r      <= 4'd1;
          round_type_r <= RT_MAIN;
          fsm_r        <= ST_MAIN;
        end

        ST_MAIN: begin
          state_r <= round_result;
          round_r <= round_r + 4'd1;
          if (round_r == last_main_s) begin
            round_type_r <= RT_FINAL;
            fsm_r        <= ST_FINAL;
          end
        end

        ST_FINAL: begin
          // state_r deliberately keeps the last main-round value here.
          new_block_r  <= round_result;
          ready_r      <= 1'b1;
          valid_r      <= 1'b1;
          round_r      <= 4'd0;
          round_type_r <= RT_INIT;
          fsm_r        <= ST_IDLE;
        end

        default: begin
          fsm_r        <= ST_IDLE;
          round_r      <= 4'd0;
          round_type_r <= RT_INIT;
          ready_r      <= 1'b1;
          valid_r      <= 1'b0;
        end
      endcase
    end
  end

  assign round       = round_r;
  assign round_type  = round_type_r;
  assign round_state = state_r;
  assign new_block   = new_block_r;
  assign ready       = ready_r;
  assign valid       = valid_r;

endmodule

// File: tb/tb_aes_encipher_ctrl.sv
// tb_aes_encipher_ctrl
// Directed bench: a stub round function (state ^ round) checks sequencing,
// and a behavioural AES-128 round plus key expansion checks the FIPS-197
// C.1 vector end to end.

module tb_aes_encipher_ctrl;

  logic         clk;
  logic         reset;
  logic         next;
  logic         keylen;
  logic [127:0] block;
  logic [3:0]   round;
  logic [1:0]   round_type;
  logic [127:0] round_state;
  logic [127:0] round_result;
  logic [127:0] new_block;
  logic         ready;
  logic         valid;

  logic         use_aes;
  logic [127:0] rk [0:15];
  logic [31:0]  w  [0:43];

  int compared;
  int mismatched;

  aes_encipher_ctrl #(.NR128(10), .NR256(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .next         (next),
    .keylen       (keylen),
    .block        (block),
    .round        (round),
    .round_type   (round_type),
    .round_state  (round_state),
    .round_result (round_result),
    .new_block    (new_block),
    .ready        (ready),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(c*4+r) -: 8] = s[127-8*((((c+r)%4)*4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(c*4+0) -: 8];
      a1 = s[127-8*(c*4+1) -: 8];
      a2 = s[127-8*(c*4+2) -: 8];
      a3 = s[127-8*(c*4+3) -: 8];
      o[127-8*(c*4+0) -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(c*4+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127-8*(c*4+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127-8*(c*4+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Round logic model: stub (state ^ round) or real AES-128 encipher round.
  always_comb begin
    if (use_aes) begin
      case (round_type)
        2'd0:    round_result = round_state ^ rk[round];
        2'd1:    round_result = mix_columns(shift_rows(sub_bytes(round_state))) ^ rk[round];
        default: round_result = shift_rows(sub_bytes(round_state)) ^ rk[round];
      endcase
    end else begin
      round_result = round_state ^ {124'd0, round};
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expand_key128(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rcon;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = 128'd0;
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One full operation: checks the round/round_type walk every cycle,
  // the latency in edges after the accepting edge, and the final result.
  // poke_round >= 0 pulses next (and scrambles keylen/block) at that round.
  task automatic run_op(input string tag, input logic kl, input logic [127:0] blk,
                        input logic [127:0] exp_blk, input int nr, input int poke_round);
    int         edges;
    logic [3:0] er;
    logic [1:0] et;
    @(negedge clk);
    next   = 1'b1;
    keylen = kl;
    block  = blk;
    @(posedge clk);
    @(negedge clk);
    next   = 1'b0;
    keylen = ~kl;
    block  = ~blk;
    check({tag, "_busy_ready"}, {127'd0, ready}, 128'd0);
    check({tag, "_busy_valid"}, {127'd0, valid}, 128'd0);
    check({tag, "_captured"}, round_state, blk);
    edges = 0;
    while (ready === 1'b0 && edges < 40) begin
      if (edges == 0) begin
        er = 4'd0; et = 2'd0;
      end else if (edges < nr) begin
        er = edges[3:0]; et = 2'd1;
      end else begin
        er = nr[3:0]; et = 2'd2;
      end
      check({tag, "_round_walk"}, {122'd0, round, round_type}, {122'd0, er, et});
      if (poke_round >= 0 && round === poke_round[3:0]) next = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
      next = 1'b0;
    end
    check({tag, "_latency"}, 128'(edges), 128'(nr + 1));
    check({tag, "_result"}, new_block, exp_blk);
    check({tag, "_valid"}, {127'd0, valid}, 128'd1);
    check({tag, "_idle_round"}, {122'd0, round, round_type}, 128'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    use_aes    = 1'b0;
    for (int r = 0; r < 16; r++) rk[r] = 128'd0;

    // Reset held for two cycles with random inputs.
    reset  = 1'b1;
    next   = 1'($urandom);
    keylen = 1'($urandom);
    block  = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {127'd0, ready}, 128'd1);
    check("rst_valid", {127'd0, valid}, 128'd0);
    check("rst_new_block", new_block, 128'd0);
    check("rst_round", {124'd0, round}, 128'd0);
    check("rst_round_type", {126'd0, round_type}, 128'd0);
    check("rst_round_state", round_state, 128'd0);
    reset = 1'b0;
    next  = 1'b0;

    // Stub sequencing, AES-128 and AES-256 round counts.
    run_op("s128", 1'b0, 128'd0, 128'h0B, 10, -1);
    repeat (3) @(negedge clk);
    check("valid_hold", {127'd0, valid}, 128'd1);
    check("result_hold", new_block, 128'h0B);
    run_op("s256", 1'b1, 128'd0, 128'h0F, 14, -1);
    run_op("s128_nz", 1'b0, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321,
           128'h1234_5678_9abc_def0_0fed_cba9_8765_432A, 10, -1);

    // next pulsed mid-run at round 5 must be ignored.
    run_op("poke", 1'b0, 128'd0, 128'h0B, 10, 5);

    // Abort at round 6 with reset, next held high across the reset edge.
    @(negedge clk);
    next   = 1'b1;
    keylen = 1'b1;
    block  = 128'd0;
    @(posedge clk);
    @(negedge clk);
    next = 1'b0;
    for (int n = 0; n < 20 && round !== 4'd6; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_at_round6", {124'd0, round}, 128'd6);
    reset = 1'b1;
    next  = 1'b1;
    block = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", {127'd0, ready}, 128'd1);
    check("abort_valid", {127'd0, valid}, 128'd0);
    check("abort_round", {122'd0, round, round_type}, 128'd0);
    check("abort_state", round_state, 128'd0);
    check("abort_new_block", new_block, 128'd0);
    reset = 1'b0;
    next  = 1'b0;
    run_op("after_abort", 1'b0, 128'd0, 128'h0B, 10, -1);

    // FIPS-197 C.1 with real round logic.
    expand_key128(128'h000102030405060708090a0b0c0d0e0f);
    use_aes = 1'b1;
    run_op("fips", 1'b0, 128'h00112233445566778899aabbccddeeff,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
